// File: rtl/morse_sequencer.sv
// Morse playback engine: buffers packed characters in a small FIFO and plays
// each symbol with dot-unit timing, including symbol, character and word gaps.
module morse_sequencer #(
  parameter int NSYM       = 5,
  parameter int DEPTH      = 4,
  parameter int UNIT_CYC   = 5000000,
  parameter int DASH_UNITS = 3,
  parameter int CGAP_UNITS = 3,
  parameter int WGAP_UNITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [2*NSYM-1:0]      wr_data,
  input  logic                   abort,
  output logic                   tone,
  output logic                   short,
  output logic                   long,
  output logic                   busy,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   char_done
);

  localparam int W  = 2 * NSYM;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (NSYM > 1) ? $clog2(NSYM) : 1;

  // GAP already supplies one unit of the character gap, so CGAP holds the rest
  localparam int  CG_UNITS  = (CGAP_UNITS > 1) ? CGAP_UNITS - 1 : 1;
  localparam bit  HAS_CGAP  = (CGAP_UNITS > 1);
  localparam int  MAXU_A    = (DASH_UNITS > WGAP_UNITS) ? DASH_UNITS : WGAP_UNITS;
  localparam int  MAXU      = (MAXU_A > CG_UNITS) ? MAXU_A : CG_UNITS;
  localparam int  TMAX      = MAXU * UNIT_CYC;
  localparam int  TW        = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T_DOT  = TW'(UNIT_CYC - 1);
  localparam logic [TW-1:0] T_DASH = TW'(DASH_UNITS * UNIT_CYC - 1);
  localparam logic [TW-1:0] T_CGAP = TW'(CG_UNITS * UNIT_CYC - 1);
  localparam logic [TW-1:0] T_WGAP = TW'(WGAP_UNITS * UNIT_CYC - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] TONE = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] CGAP = 3'd3;
  localparam logic [2:0] WGAP = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          dash_q, dash_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          tone_q, tone_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          done_q, done_d;

  logic          pop, push, fifo_full, tmr_done, next_end;
  logic [TW-1:0] tmr_last;
  logic [W-1:0]  head, nxt_sr;

  function automatic logic [2:0] sym_state(input logic [1:0] s);
    case (s)
      2'b01, 2'b10: sym_state = TONE;
      2'b11:        sym_state = WGAP;
      default:      sym_state = IDLE;
    endcase
  endfunction

  assign fifo_full = (count_q == CW'(DEPTH));
  assign head      = mem_q[rd_ptr_q];
  assign nxt_sr    = sr_q >> 2;
  assign next_end  = (idx_q == IW'(NSYM - 1)) || (nxt_sr[1:0] == 2'b00);
  assign tmr_done  = (tmr_q == tmr_last);

  always_comb begin
    case (state_q)
      TONE:    tmr_last = dash_q ? T_DASH : T_DOT;
      CGAP:    tmr_last = T_CGAP;
      WGAP:    tmr_last = T_WGAP;
      default: tmr_last = T_DOT;
    endcase
  end

  // Playback FSM; every state change restarts the cycle timer
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TW'(1);
    sr_d    = sr_q;
    idx_d   = idx_q;
    dash_d  = dash_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          sr_d    = head;
          idx_d   = '0;
          dash_d  = head[1] & ~head[0];
          state_d = sym_state(head[1:0]);
          if (head[1:0] == 2'b00) done_d = 1'b1;
        end
      end
      TONE: begin
        if (tmr_done) begin
          state_d = GAP;
          tmr_d   = '0;
        end
      end
      GAP, WGAP: begin
        if (tmr_done) begin
          tmr_d = '0;
          if (next_end) begin
            if (HAS_CGAP) begin
              state_d = CGAP;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            sr_d    = nxt_sr;
            idx_d   = idx_q + IW'(1);
            dash_d  = nxt_sr[1] & ~nxt_sr[0];
            state_d = sym_state(nxt_sr[1:0]);
          end
        end
      end
      CGAP: begin
        if (tmr_done) begin
          state_d = IDLE;
          tmr_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      tmr_d   = '0;
      done_d  = 1'b0;
      pop     = 1'b0;
    end
  end

  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands
  always_comb begin
    push     = wr_en && !abort && (!fifo_full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q | (wr_en & ~push);
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_comb begin
    tone_d  = (state_d == TONE);
    short_d = tone_d & ~dash_d;
    long_d  = tone_d & dash_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      sr_q     <= '0;
      idx_q    <= '0;
      dash_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tone_q   <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      dash_q   <= dash_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tone_q   <= tone_d;
      short_q  <= short_d;
      long_q   <= long_d;
      done_q   <= done_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign tone      = tone_q;
  assign short     = short_q;
  assign long      = long_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign full      = fifo_full;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign char_done = done_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: a queue-based model expands each character into
// its per-cycle output waveform and is compared against the DUT every cycle.
module tb_morse_sequencer;

  localparam int NSYM       = 5;
  localparam int DEPTH      = 4;
  localparam int UNIT_CYC   = 4;
  localparam int DASH_UNITS = 3;
  localparam int CGAP_UNITS = 3;
  localparam int WGAP_UNITS = 4;
  localparam int W          = 2 * NSYM;
  localparam int CW         = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          abort;
  logic          tone, short, long, busy, full, overflow, char_done;
  logic [CW-1:0] count;

  morse_sequencer #(
    .NSYM(NSYM), .DEPTH(DEPTH), .UNIT_CYC(UNIT_CYC), .DASH_UNITS(DASH_UNITS),
    .CGAP_UNITS(CGAP_UNITS), .WGAP_UNITS(WGAP_UNITS)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .abort(abort),
    .tone(tone), .short(short), .long(long), .busy(busy), .full(full),
    .count(count), .overflow(overflow), .char_done(char_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic active;
    logic tone;
    logic shrt;
    logic lng;
    logic done;
  } ent_t;

  ent_t         play[$];
  logic [W-1:0] mq[$];
  logic         m_ovf;
  bit           checking = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  int tone_cyc, short_cyc, long_cyc, done_cnt;
  int last_wr_edge, last_done_edge;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_seg(input int n, input logic t, input logic s, input logic l);
    ent_t e;
    e.active = 1'b1;
    e.tone   = t;
    e.shrt   = s;
    e.lng    = l;
    e.done   = 1'b0;
    for (int i = 0; i < n; i++) play.push_back(e);
  endfunction

  // Waveform of one character, one entry per cycle following the pop edge
  function automatic void expand_char(input logic [W-1:0] c);
    int         n = 0;
    logic [1:0] s;
    ent_t       e;
    for (int i = 0; i < NSYM; i++) begin
      s = c[2*i +: 2];
      if (s == 2'b00) break;
      n++;
      case (s)
        2'b01: begin
          push_seg(UNIT_CYC, 1'b1, 1'b1, 1'b0);
          push_seg(UNIT_CYC, 1'b0, 1'b0, 1'b0);
        end
        2'b10: begin
          push_seg(DASH_UNITS * UNIT_CYC, 1'b1, 1'b0, 1'b1);
          push_seg(UNIT_CYC, 1'b0, 1'b0, 1'b0);
        end
        default: push_seg(WGAP_UNITS * UNIT_CYC, 1'b0, 1'b0, 1'b0);
      endcase
    end
    if (n > 0) push_seg((CGAP_UNITS - 1) * UNIT_CYC, 1'b0, 1'b0, 1'b0);
    e = '0;
    e.done = 1'b1;
    play.push_back(e);
  endfunction

  // Model step and full output compare once per clock edge
  initial begin
    ent_t         e;
    logic [W-1:0] head;
    bit           pop;
    forever begin
      @(posedge clk);
      cyc++;
      e = '0;
      if (reset) begin
        mq.delete();
        play.delete();
        m_ovf = 1'b0;
      end else if (abort) begin
        mq.delete();
        play.delete();
        m_ovf = 1'b0;
      end else begin
        pop = (play.size() == 0) && (mq.size() > 0);
        if (pop) begin
          head = mq.pop_front();
          expand_char(head);
        end
        if (wr_en) begin
          if (mq.size() < DEPTH) begin
            mq.push_back(wr_data);
            last_wr_edge = cyc;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (play.size() > 0) e = play.pop_front();
      end
      #1;
      if (checking) begin
        checkOutput("tone", tone, e.tone);
        checkOutput("short", short, e.shrt);
        checkOutput("long", long, e.lng);
        checkOutput("char_done", char_done, e.done);
        checkOutput("busy", busy, e.active || (mq.size() > 0));
        checkOutput("full", full, mq.size() == DEPTH);
        checkOutput("count", count, mq.size());
        checkOutput("overflow", overflow, m_ovf);
        tone_cyc  += tone;
        short_cyc += short;
        long_cyc  += long;
        if (char_done) begin
          done_cnt++;
          last_done_edge = cyc;
        end
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic [W-1:0] d, input logic a);
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    abort   = a;
  endtask

  task automatic write_char(input logic [W-1:0] d);
    applyStimulus(1'b1, d, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_idle", busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic clear_stats();
    tone_cyc  = 0;
    short_cyc = 0;
    long_cyc  = 0;
    done_cnt  = 0;
  endtask

  initial begin
    int n;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    abort   = 1'b0;
    clear_stats();
    #1 reset = 1'b1;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_tone", tone, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_ovf", overflow, 1'b0);
    checkOutput("rst_done", char_done, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] letter A");
    clear_stats();
    write_char(10'h009);
    wait_idle(200);
    checkOutput("A_tone_cycles", tone_cyc, 16);
    checkOutput("A_short_cycles", short_cyc, 4);
    checkOutput("A_long_cycles", long_cyc, 12);
    checkOutput("A_done_pulses", done_cnt, 1);
    checkOutput("A_latency", last_done_edge - last_wr_edge, 33);

    $display("[TB] empty character");
    clear_stats();
    write_char(10'h000);
    wait_idle(50);
    checkOutput("empty_done_pulses", done_cnt, 1);
    checkOutput("empty_latency", last_done_edge - last_wr_edge, 1);
    checkOutput("empty_tone_cycles", tone_cyc, 0);

    $display("[TB] word gap only");
    clear_stats();
    write_char(10'h003);
    wait_idle(100);
    checkOutput("wgap_done_pulses", done_cnt, 1);
    checkOutput("wgap_latency", last_done_edge - last_wr_edge, 25);
    checkOutput("wgap_tone_cycles", tone_cyc, 0);

    $display("[TB] fill and overflow");
    clear_stats();
    applyStimulus(1'b1, 10'h2AA, 1'b0);
    repeat (4) applyStimulus(1'b1, 10'h001, 1'b0);
    applyStimulus(1'b1, 10'h002, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("fill_count", count, 4);
    checkOutput("fill_full", full, 1'b1);
    checkOutput("fill_overflow", overflow, 1'b1);
    n = 0;
    while (!char_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_done", char_done, 1'b1);
    wr_en   = 1'b1;
    wr_data = 10'h001;
    @(negedge clk);
    wr_en = 1'b0;
    checkOutput("pushpop_count", count, 4);
    wait_idle(600);
    checkOutput("fill_done_pulses", done_cnt, 6);
    checkOutput("fill_long_cycles", long_cyc, 60);

    $display("[TB] abort mid-dash");
    clear_stats();
    applyStimulus(1'b1, 10'h002, 1'b0);
    applyStimulus(1'b1, 10'h001, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("pre_abort_long", long, 1'b1);
    applyStimulus(1'b1, 10'h001, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("abort_tone", tone, 1'b0);
    checkOutput("abort_count", count, 0);
    checkOutput("abort_ovf", overflow, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", done_cnt, 0);
    write_char(10'h001);
    wait_idle(100);
    checkOutput("post_abort_done", done_cnt, 1);
    checkOutput("post_abort_latency", last_done_edge - last_wr_edge, 17);

    $display("[TB] reset during tone");
    write_char(10'h002);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_tone", tone, 1'b0);
    checkOutput("arst_long", long, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_count", count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 1'b0);
    checkOutput("post_rst_count", count, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 199) == 0);
    end
    applyStimulus(1'b0, '0, 1'b0);
    wait_idle(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
